uart_peripheral: RTL

Memory-mapped 8N1 UART sitting beside the LED/anode output register on the CPU data bus. It decodes its own three word addresses, so the bus-side read mux can OR its `Read_data` with the other peripherals. It serialises bytes written by software onto `uart_tx` and deserialises `uart_rx` into a receive register with status flags.

---
 rtl/uart_pkg.sv | 39 +++
 rtl/uart_rx_core.sv | 106 ++++++++++
 rtl/uart_peripheral.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the memory-mapped UART: default register addresses,
// control/status bit positions, FSM state encodings and the baud divider.
// ---------------------------------------------------------------------------
package uart_pkg;

  // Default word addresses of the three UART registers.
  localparam logic [31:0] ADDR_TXD_DEFAULT = 32'h4000_0018;
  localparam logic [31:0] ADDR_RXD_DEFAULT = 32'h4000_001C;
  localparam logic [31:0] ADDR_CON_DEFAULT = 32'h4000_0020;

  // Bit positions inside the control/status register.
  localparam int CON_TX_BUSY  = 0;
  localparam int CON_RX_VALID = 1;
  localparam int CON_RX_OVR   = 2;
  localparam int CON_TX_OVR   = 3;
  localparam int CON_FRM_ERR  = 4;

  // Transmitter states.
  typedef logic [1:0] tx_state_t;
  localparam tx_state_t TX_IDLE  = 2'd0;
  localparam tx_state_t TX_START = 2'd1;
  localparam tx_state_t TX_DATA  = 2'd2;
  localparam tx_state_t TX_STOP  = 2'd3;

  // Receiver states.
  typedef logic [1:0] rx_state_t;
  localparam rx_state_t RX_IDLE  = 2'd0;
  localparam rx_state_t RX_START = 2'd1;
  localparam rx_state_t RX_DATA  = 2'd2;
  localparam rx_state_t RX_STOP  = 2'd3;

  // Clock cycles per bit, truncated. Callers must keep the result >= 4.
  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
// 8N1 receiver: 2-flop synchronizer, start-bit qualification at half a bit,
// mid-bit sampling of 8 data bits (LSB first) and one stop-bit sample.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   rx                asynchronous serial input, idle high
//   byte_out[7:0]     assembled byte, valid while byte_strobe is high
//   byte_strobe       one-cycle pulse: stop bit sampled high
//   frame_err_strobe  one-cycle pulse: stop bit sampled low
// ---------------------------------------------------------------------------
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_out,
  output logic       byte_strobe,
  output logic       frame_err_strobe
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync_meta;
  logic          sync_q;
  logic          sync_prev;
  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          stop_sample;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours regardless of block order.
  // The synchronizer resets to the idle level; resetting it low would look
  // like a start-bit edge once rst is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 1'b1;
      sync_q    <= 1'b1;
      sync_prev <= 1'b1;
    end else begin
      sync_meta <= rx;
      sync_q    <= sync_meta;
      sync_prev <= sync_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RX_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (sync_prev && !sync_q) state <= RX_START;
        end
        RX_START: begin
          // Half a bit in: a line that is high again was only a glitch.
          if (cnt == CNT_HALF) begin
            cnt   <= '0;
            idx   <= '0;
            state <= sync_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            shift <= {sync_q, shift[7:1]};
            idx   <= idx + 3'd1;
            if (idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin  // RX_STOP
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= RX_IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
      endcase
    end
  end

  // The stop sample happens on the cycle the STOP bit counter expires; the
  // strobes are combinational so the register file reacts at that same edge.
  assign stop_sample      = (state == RX_STOP) && (cnt == CNT_LAST);
  assign byte_strobe      = stop_sample && sync_q;
  assign frame_err_strobe = stop_sample && !sync_q;
  assign byte_out         = shift;

endmodule

// File: rtl/uart_peripheral.sv
// ---------------------------------------------------------------------------
// uart_peripheral
// Memory-mapped 8N1 UART on the CPU data bus. Decodes its own TXD, RXD and
// CON addresses; Read_data is zero unless one of them is read, so it can be
// OR-ed with other peripherals' read data.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   MemRead/MemWrite  bus read / write strobes
//   Address[31:0]     byte address
//   Write_data[31:0]  write data
//   Read_data[31:0]   combinational read data
//   uart_rx           asynchronous serial input, idle high
//   uart_tx           serial output, idle high
// ---------------------------------------------------------------------------
module uart_peripheral
  import uart_pkg::*;
#(
  parameter int          CLK_FREQ = 100_000_000,
  parameter int          BAUD     = 9600,
  parameter logic [31:0] ADDR_TXD = ADDR_TXD_DEFAULT,
  parameter logic [31:0] ADDR_RXD = ADDR_RXD_DEFAULT,
  parameter logic [31:0] ADDR_CON = ADDR_CON_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Bus decode.
  logic txd_wr, con_wr, rxd_rd;
  assign txd_wr = MemWrite && (Address == ADDR_TXD);
  assign con_wr = MemWrite && (Address == ADDR_CON);
  assign rxd_rd = MemRead  && (Address == ADDR_RXD);

  // Only the flag-clear bits of a CON write and the byte of a TXD write matter.
  logic unused_wdata;
  assign unused_wdata = ^{Write_data[31:8], Write_data[1:0]};

  // ---------------- Transmitter ----------------
  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_shift;
  logic          tx_line;
  logic          tx_busy;

  assign tx_busy = (tx_state != TX_IDLE);
  assign uart_tx = tx_line;

  // The line is registered and updated on the same edge as the state, so the
  // start bit appears right after the accepting edge and reset forces it high.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (txd_wr) begin
            tx_state <= TX_START;
            tx_cnt   <= '0;
            tx_shift <= Write_data[7:0];
            tx_line  <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_state <= TX_DATA;
            tx_line  <= tx_shift[0];
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        TX_DATA: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt <= '0;
            if (tx_idx == 3'd7) begin
              tx_state <= TX_STOP;
              tx_line  <= 1'b1;
            end else begin
              tx_idx   <= tx_idx + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_line  <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        default: begin  // TX_STOP
          if (tx_cnt == CNT_LAST) begin
            tx_cnt   <= '0;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
      endcase
    end
  end

  // ---------------- Receiver ----------------
  logic [7:0] rx_byte;
  logic       rx_byte_stb;
  logic       rx_ferr_stb;

  uart_rx_core #(
    .DIV(DIV)
  ) u_rx_core (
    .clk             (clk),
    .rst             (rst),
    .rx              (uart_rx),
    .byte_out        (rx_byte),
    .byte_strobe     (rx_byte_stb),
    .frame_err_strobe(rx_ferr_stb)
  );

  // ---------------- Data register and flags ----------------
  logic [7:0] rx_data;
  logic       rx_valid, rx_ovr, tx_ovr, frm_err;

  // Every flag follows "set wins": a set event in the same cycle as a clear
  // (CON write or RXD read) leaves the flag at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_ovr   <= 1'b0;
      tx_ovr   <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      if (rx_byte_stb) rx_data <= rx_byte;
      rx_valid <= rx_byte_stb || (rx_valid && !rxd_rd);
      // A byte landing while software reads the previous one is not an overrun.
      rx_ovr   <= (rx_byte_stb && rx_valid && !rxd_rd) ||
                  (rx_ovr && !(con_wr && Write_data[CON_RX_OVR]));
      tx_ovr   <= (txd_wr && tx_busy) ||
                  (tx_ovr && !(con_wr && Write_data[CON_TX_OVR]));
      frm_err  <= rx_ferr_stb ||
                  (frm_err && !(con_wr && Write_data[CON_FRM_ERR]));
    end
  end

  // NOTE: the default assignment at the top keeps this block free of
  // inferred latches for every address that falls through.
  always_comb begin
    Read_data = '0;
    if (MemRead) begin
      if (Address == ADDR_RXD) begin
        Read_data = {24'b0, rx_data};
      end else if (Address == ADDR_CON) begin
        Read_data = {27'b0, frm_err, tx_ovr, rx_ovr, rx_valid, tx_busy};
      end
    end
  end

endmodule
